gme_pipe: RTL and testbench
===========================

# gme_pipe

Parametrised next-generation generic match engine stage. It forwards lookup keys to the lookup engine and buffers MD/PHV in internal FIFOs. It merges each lookup result (index word with hit bit) into the MD of packets addressed to this stage, and emits MD/PHV to the next module under downstream backpressure. Optionally it drops packets on lookup miss. It sits in the pipeline between the previous parser/match stage and the next module; the config packet path passes straight through.

## Interface
- LMID, 8'd3, module ID this stage serves (MD[MID_LSB+:8])
- NMID, 8'd7, module ID written into MD of served packets
- MD_W, 256, metadata width
- PHV_W, 1024, PHV width
- KEY_W, 512, key width
- IDX_W, 16, index word width; bit IDX_W-1 = hit, [IDX_W-2:0] = index value
- MID_LSB, 80, LSB of module-ID byte in MD
- IDX_LSB, 48, LSB of index field in MD; IDX_LSB+IDX_W <= MID_LSB
- AW, 8, FIFO address width; depth D = 2^AW, all three FIFOs
- ALF_MARGIN, 6, almost-full asserted when usedw > D-ALF_MARGIN
- DROP_MISS, 0, 1 = discard MD/PHV of served packet on miss
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_gme_key / in_gme_key_wr / out_gme_key_alf  in/in/out  KEY_W/1/1  key from previous module
- in_gme_md / in_gme_md_wr / out_gme_md_alf  in/in/out  MD_W/1/1  MD from previous module
- in_gme_phv / in_gme_phv_wr / out_gme_phv_alf  in/in/out  PHV_W/1/1  PHV from previous module
- in_gme_index / in_gme_index_wr / out_gme_index_alf  in/in/out  IDX_W/1/1  result from lookup
- out_gme_key / out_gme_key_wr / in_gme_key_alf  out/out/in  KEY_W/1/1  key to lookup
- out_gme_md / out_gme_md_wr / in_gme_md_alf  out/out/in  MD_W/1/1  MD to next module
- out_gme_phv / out_gme_phv_wr / in_gme_phv_alf  out/out/in  PHV_W/1/1  PHV to next module
- cin_gme_data / cin_gme_data_wr / cout_gme_ready  in/in/out  134/1/1  config packet in
- cout_gme_data / cout_gme_data_wr / cin_gme_ready  out/out/in  134/1/1  config packet out
- cnt_in_md, cnt_out_md, cnt_hit, cnt_miss, cnt_drop  out  32 each  statistics
- err_ovf  out  1  sticky: a write was attempted to a full FIFO

## Operation
- Config path combinational: cout_gme_data=cin_gme_data, cout_gme_data_wr=cin_gme_data_wr, cout_gme_ready=cin_gme_ready.
- Key path: when in_gme_key_wr=1 and in_gme_md[MID_LSB+:8]==LMID, register key and set out_gme_key_wr=1 next cycle. Otherwise out_gme_key_wr=0 and out_gme_key holds its value. out_gme_key_alf=in_gme_key_alf.
- FIFOs are synchronous and show-ahead (head visible while not empty), with usedw of AW+1 bits. A write is accepted iff usedw<D before that cycle's pop. A write while full is discarded and sets err_ovf.
- out_gme_md_alf = in_gme_md_alf | (md_usedw > D-ALF_MARGIN). PHV alf is analogous. out_gme_index_alf = idx_usedw > D-ALF_MARGIN.
- FSM IDLE:
  - Requires MD and PHV FIFOs non-empty, and in_gme_md_alf=0 and in_gme_phv_alf=0.
  - If head MD module ID != LMID: pop MD+PHV, mode PASS, go EMIT.
  - If == LMID: wait while the index FIFO is empty. Otherwise pop MD+PHV+index and go EMIT. Mode is DROP if index hit=0 and DROP_MISS=1, else MERGE.
- FSM EMIT (one cycle), then IDLE:
  - PASS: out MD=head MD unchanged.
  - MERGE: out MD = head MD with [MID_LSB+:8]=NMID and [IDX_LSB+:IDX_W]=index word.
  - In both PASS and MERGE, out MD/PHV wr=1 for exactly one cycle.
  - DROP: no write, cnt_drop++.
- Counters are 32-bit and wrap at 2^32-1→0:
  - cnt_in_md: accepted MD writes.
  - cnt_out_md: out_gme_md_wr cycles.
  - cnt_hit / cnt_miss: each popped index word, by hit bit.
- out_gme_md_wr and out_gme_phv_wr are always simultaneous. MD/PHV order is preserved, and indices are consumed in order by served packets only.

## Timing
- Reset values: all outputs 0 (out_gme_key, out_gme_md, out_gme_phv, wr strobes, counters, err_ovf). The FSM is in IDLE and FIFOs are empty. Config outputs follow their inputs.
- Reset mid-operation discards FIFO contents and any packet in EMIT; no partial output.
- Key latency: 1 cycle.
- MD/PHV minimum latency: write at cycle t → out wr at t+2 (pass), or t+2 if the index arrived by t.
- Throughput: one packet per 2 cycles.
- Downstream alf is sampled only in IDLE. A packet already in EMIT completes regardless.
- Outputs are 0 in the cycle after EMIT (IDLE drives strobes 0, data 0).

## Test plan
- Pass-through: MD module ID=8'd5 with PHV=1024'hA5 → out MD identical, out PHV=1024'hA5 at t+2, no key out, cnt_out_md=1.
- Merge hit: MD module ID=3, key=512'h1234 → out_gme_key_wr at t+1. Then index 16'h8123 → out MD[87:80]=7 and MD[63:48]=16'h8123, cnt_hit=1.
- Miss with DROP_MISS=1: index 16'h0042 → no output, cnt_drop=1, cnt_miss=1. The next pass packet is still emitted.
- Backpressure: hold in_gme_md_alf=1 with 3 packets queued → no output. Release → 3 outputs at 2-cycle spacing, in order.
- Full/alf: with D=256, write 251 MD → out_gme_md_alf=1 after the 251st. Writes 257+ → discarded, err_ovf=1, cnt_in_md=256.
- Async reset asserted during EMIT → all outputs 0 immediately. After release, FIFOs are empty and no stale output appears.

Source files
------------

// File: rtl/gme_pipe_if.sv
// gme_pipe_if: groups the data/strobe/almost-full signals of one gme_pipe stage.
//   Upstream in  : in_gme_key/_wr, in_gme_md/_wr, in_gme_phv/_wr, in_gme_index/_wr
//   Upstream out : out_gme_key_alf, out_gme_md_alf, out_gme_phv_alf, out_gme_index_alf
//   Downstream   : out_gme_key/_wr, out_gme_md/_wr, out_gme_phv/_wr with in_*_alf back
//   Config path  : cin_gme_data/_wr, cout_gme_ready -> cout_gme_data/_wr, cin_gme_ready
// Modport slave is the stage itself; master is the surrounding environment.
interface gme_pipe_if #(
   parameter int unsigned MD_W  = 256,
   parameter int unsigned PHV_W = 1024,
   parameter int unsigned KEY_W = 512,
   parameter int unsigned IDX_W = 16,
   parameter int unsigned CFG_W = 134
);
   logic [KEY_W-1:0] in_gme_key;
   logic             in_gme_key_wr;
   logic             out_gme_key_alf;
   logic [MD_W-1:0]  in_gme_md;
   logic             in_gme_md_wr;
   logic             out_gme_md_alf;
   logic [PHV_W-1:0] in_gme_phv;
   logic             in_gme_phv_wr;
   logic             out_gme_phv_alf;
   logic [IDX_W-1:0] in_gme_index;
   logic             in_gme_index_wr;
   logic             out_gme_index_alf;

   logic [KEY_W-1:0] out_gme_key;
   logic             out_gme_key_wr;
   logic             in_gme_key_alf;
   logic [MD_W-1:0]  out_gme_md;
   logic             out_gme_md_wr;
   logic             in_gme_md_alf;
   logic [PHV_W-1:0] out_gme_phv;
   logic             out_gme_phv_wr;
   logic             in_gme_phv_alf;

   logic [CFG_W-1:0] cin_gme_data;
   logic             cin_gme_data_wr;
   logic             cout_gme_ready;
   logic [CFG_W-1:0] cout_gme_data;
   logic             cout_gme_data_wr;
   logic             cin_gme_ready;

   modport slave (
      input  in_gme_key, in_gme_key_wr, in_gme_md, in_gme_md_wr, in_gme_phv, in_gme_phv_wr,
             in_gme_index, in_gme_index_wr, in_gme_key_alf, in_gme_md_alf, in_gme_phv_alf,
             cin_gme_data, cin_gme_data_wr, cin_gme_ready,
      output out_gme_key_alf, out_gme_md_alf, out_gme_phv_alf, out_gme_index_alf,
             out_gme_key, out_gme_key_wr, out_gme_md, out_gme_md_wr, out_gme_phv,
             out_gme_phv_wr, cout_gme_ready, cout_gme_data, cout_gme_data_wr
   );

   modport master (
      output in_gme_key, in_gme_key_wr, in_gme_md, in_gme_md_wr, in_gme_phv, in_gme_phv_wr,
             in_gme_index, in_gme_index_wr, in_gme_key_alf, in_gme_md_alf, in_gme_phv_alf,
             cin_gme_data, cin_gme_data_wr, cin_gme_ready,
      input  out_gme_key_alf, out_gme_md_alf, out_gme_phv_alf, out_gme_index_alf,
             out_gme_key, out_gme_key_wr, out_gme_md, out_gme_md_wr, out_gme_phv,
             out_gme_phv_wr, cout_gme_ready, cout_gme_data, cout_gme_data_wr
   );
endinterface

// File: rtl/gme_pipe.sv
// gme_pipe: generic match engine stage.
// Forwards keys of packets addressed to LMID to the lookup engine, buffers MD/PHV and
// lookup results in three show-ahead FIFOs, merges each result into the MD of served
// packets (or drops them on miss when DROP_MISS=1) and emits MD/PHV downstream.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     key/MD/PHV/index/config streams, see gme_pipe_if
//   cnt_*           32-bit wrapping statistics (in MD, out MD, hit, miss, drop)
//   err_ovf         sticky: a write hit a full FIFO
module gme_pipe #(
   parameter logic [7:0]  LMID       = 8'd3,
   parameter logic [7:0]  NMID       = 8'd7,
   parameter int unsigned MD_W       = 256,
   parameter int unsigned PHV_W      = 1024,
   parameter int unsigned KEY_W      = 512,
   parameter int unsigned IDX_W      = 16,
   parameter int unsigned MID_LSB    = 80,
   parameter int unsigned IDX_LSB    = 48,
   parameter int unsigned AW         = 8,
   parameter int unsigned ALF_MARGIN = 6,
   parameter bit          DROP_MISS  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   gme_pipe_if.slave   bus,
   output logic [31:0] cnt_in_md,
   output logic [31:0] cnt_out_md,
   output logic [31:0] cnt_hit,
   output logic [31:0] cnt_miss,
   output logic [31:0] cnt_drop,
   output logic        err_ovf
);

   localparam int unsigned D       = 2 ** AW;
   localparam logic [AW:0] DEPTH   = (AW+1)'(D);
   localparam logic [AW:0] ALF_LVL = (AW+1)'(D - ALF_MARGIN);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;
   typedef enum logic [1:0] {ModePass, ModeMerge, ModeDrop} mode_e;

   state_e state_q, state_d;
   mode_e  mode_q, mode_d;

   // ---------------------------------------------------------------- config path
   assign bus.cout_gme_data    = bus.cin_gme_data;
   assign bus.cout_gme_data_wr = bus.cin_gme_data_wr;
   assign bus.cout_gme_ready   = bus.cin_gme_ready;

   // ---------------------------------------------------------------- key path
   logic [KEY_W-1:0] key_q;
   logic             key_wr_q;
   logic             key_hit;

   // The key belongs to the MD presented in the same cycle.
   assign key_hit = bus.in_gme_key_wr && (bus.in_gme_md[MID_LSB +: 8] == LMID);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q    <= '0;
         key_wr_q <= 1'b0;
      end else begin
         key_wr_q <= key_hit;
         if (key_hit) key_q <= bus.in_gme_key;
      end
   end

   assign bus.out_gme_key     = key_q;
   assign bus.out_gme_key_wr  = key_wr_q;
   assign bus.out_gme_key_alf = bus.in_gme_key_alf;

   // ---------------------------------------------------------------- MD FIFO
   logic [MD_W-1:0] md_mem [D];
   logic [AW-1:0]   md_wp_q, md_rp_q;
   logic [AW:0]     md_cnt_q;
   logic            md_full, md_empty, md_push, md_pop;
   logic [MD_W-1:0] md_head;

   assign md_full  = (md_cnt_q == DEPTH);
   assign md_empty = (md_cnt_q == '0);
   // Fullness is judged before this cycle's pop, so a full FIFO never accepts.
   assign md_push  = bus.in_gme_md_wr && !md_full;
   assign md_head  = md_mem[md_rp_q];

   always_ff @(posedge clk) begin
      if (md_push) md_mem[md_wp_q] <= bus.in_gme_md;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_wp_q  <= '0;
         md_rp_q  <= '0;
         md_cnt_q <= '0;
      end else begin
         if (md_push) md_wp_q <= md_wp_q + AW'(1);
         if (md_pop)  md_rp_q <= md_rp_q + AW'(1);
         md_cnt_q <= md_cnt_q + (AW+1)'(md_push) - (AW+1)'(md_pop);
      end
   end

   // ---------------------------------------------------------------- PHV FIFO
   logic [PHV_W-1:0] phv_mem [D];
   logic [AW-1:0]    phv_wp_q, phv_rp_q;
   logic [AW:0]      phv_cnt_q;
   logic             phv_full, phv_empty, phv_push, phv_pop;
   logic [PHV_W-1:0] phv_head;

   assign phv_full  = (phv_cnt_q == DEPTH);
   assign phv_empty = (phv_cnt_q == '0);
   assign phv_push  = bus.in_gme_phv_wr && !phv_full;
   assign phv_head  = phv_mem[phv_rp_q];

   always_ff @(posedge clk) begin
      if (phv_push) phv_mem[phv_wp_q] <= bus.in_gme_phv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phv_wp_q  <= '0;
         phv_rp_q  <= '0;
         phv_cnt_q <= '0;
      end else begin
         if (phv_push) phv_wp_q <= phv_wp_q + AW'(1);
         if (phv_pop)  phv_rp_q <= phv_rp_q + AW'(1);
         phv_cnt_q <= phv_cnt_q + (AW+1)'(phv_push) - (AW+1)'(phv_pop);
      end
   end

   // ---------------------------------------------------------------- index FIFO
   logic [IDX_W-1:0] idx_mem [D];
   logic [AW-1:0]    idx_wp_q, idx_rp_q;
   logic [AW:0]      idx_cnt_q;
   logic             idx_full, idx_empty, idx_push, idx_pop;
   logic [IDX_W-1:0] idx_head;

   assign idx_full  = (idx_cnt_q == DEPTH);
   assign idx_empty = (idx_cnt_q == '0);
   assign idx_push  = bus.in_gme_index_wr && !idx_full;
   assign idx_head  = idx_mem[idx_rp_q];

   always_ff @(posedge clk) begin
      if (idx_push) idx_mem[idx_wp_q] <= bus.in_gme_index;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_wp_q  <= '0;
         idx_rp_q  <= '0;
         idx_cnt_q <= '0;
      end else begin
         if (idx_push) idx_wp_q <= idx_wp_q + AW'(1);
         if (idx_pop)  idx_rp_q <= idx_rp_q + AW'(1);
         idx_cnt_q <= idx_cnt_q + (AW+1)'(idx_push) - (AW+1)'(idx_pop);
      end
   end

   assign bus.out_gme_md_alf    = bus.in_gme_md_alf  | (md_cnt_q  > ALF_LVL);
   assign bus.out_gme_phv_alf   = bus.in_gme_phv_alf | (phv_cnt_q > ALF_LVL);
   assign bus.out_gme_index_alf = (idx_cnt_q > ALF_LVL);

   // ---------------------------------------------------------------- control FSM
   logic [MD_W-1:0] md_merged;

   always_comb begin
      md_merged                     = md_head;
      md_merged[MID_LSB +: 8]       = NMID;
      md_merged[IDX_LSB +: IDX_W]   = idx_head;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      md_pop  = 1'b0;
      phv_pop = 1'b0;
      idx_pop = 1'b0;
      case (state_q)
         StIdle: begin
            if (!md_empty && !phv_empty && !bus.in_gme_md_alf && !bus.in_gme_phv_alf) begin
               if (md_head[MID_LSB +: 8] != LMID) begin
                  md_pop  = 1'b1;
                  phv_pop = 1'b1;
                  mode_d  = ModePass;
                  state_d = StEmit;
               end else if (!idx_empty) begin
                  md_pop  = 1'b1;
                  phv_pop = 1'b1;
                  idx_pop = 1'b1;
                  mode_d  = (!idx_head[IDX_W-1] && DROP_MISS) ? ModeDrop : ModeMerge;
                  state_d = StEmit;
               end
            end
         end
         StEmit: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= ModePass;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
      end
   end

   // Output registers are loaded on the pop edge so they are live exactly during EMIT
   // and return to zero on the following edge.
   logic [MD_W-1:0]  out_md_q;
   logic [PHV_W-1:0] out_phv_q;
   logic             out_wr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_md_q  <= '0;
         out_phv_q <= '0;
         out_wr_q  <= 1'b0;
      end else begin
         out_md_q  <= '0;
         out_phv_q <= '0;
         out_wr_q  <= 1'b0;
         if (md_pop && (mode_d != ModeDrop)) begin
            out_wr_q  <= 1'b1;
            out_md_q  <= (mode_d == ModeMerge) ? md_merged : md_head;
            out_phv_q <= phv_head;
         end
      end
   end

   assign bus.out_gme_md     = out_md_q;
   assign bus.out_gme_md_wr  = out_wr_q;
   assign bus.out_gme_phv    = out_phv_q;
   assign bus.out_gme_phv_wr = out_wr_q;

   // ---------------------------------------------------------------- statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_in_md  <= '0;
         cnt_out_md <= '0;
         cnt_hit    <= '0;
         cnt_miss   <= '0;
         cnt_drop   <= '0;
         err_ovf    <= 1'b0;
      end else begin
         if (md_push)  cnt_in_md  <= cnt_in_md + 32'd1;
         if (out_wr_q) cnt_out_md <= cnt_out_md + 32'd1;
         if (idx_pop &&  idx_head[IDX_W-1]) cnt_hit  <= cnt_hit + 32'd1;
         if (idx_pop && !idx_head[IDX_W-1]) cnt_miss <= cnt_miss + 32'd1;
         if ((state_q == StEmit) && (mode_q == ModeDrop)) cnt_drop <= cnt_drop + 32'd1;
         if ((bus.in_gme_md_wr && md_full) || (bus.in_gme_phv_wr && phv_full) ||
             (bus.in_gme_index_wr && idx_full)) begin
            err_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gme_pipe.sv
module tb_gme_pipe;
   logic clk;
   logic rst_n;
   logic [31:0] cnt_in_md, cnt_out_md, cnt_hit, cnt_miss, cnt_drop;
   logic        err_ovf;

   gme_pipe_if bus ();

   gme_pipe #(
      .LMID(8'd3), .NMID(8'd7), .MD_W(256), .PHV_W(1024), .KEY_W(512), .IDX_W(16),
      .MID_LSB(80), .IDX_LSB(48), .AW(8), .ALF_MARGIN(6), .DROP_MISS(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .cnt_in_md(cnt_in_md), .cnt_out_md(cnt_out_md), .cnt_hit(cnt_hit),
      .cnt_miss(cnt_miss), .cnt_drop(cnt_drop), .err_ovf(err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_seen = 0;
   int wr_cyc[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input bit ok, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ behavioural model
   typedef struct packed {
      logic [255:0]  md;
      logic [1023:0] phv;
   } pkt_t;

   pkt_t        pend_q[$];   // accepted, not yet resolved against an index
   pkt_t        exp_q[$];    // expected downstream emissions, in order
   logic [15:0] idx_q[$];
   int unsigned m_in, m_out, m_hit, m_miss, m_drop;

   function automatic logic [255:0] mk_md(input logic [7:0] mid, input logic [31:0] tag);
      logic [255:0] r;
      r = {8{tag}};
      r[87:80] = mid;
      return r;
   endfunction

   task automatic model_reset();
      pend_q.delete();
      exp_q.delete();
      idx_q.delete();
      m_in = 0; m_out = 0; m_hit = 0; m_miss = 0; m_drop = 0;
   endtask

   // Served packets consume indices in order; others pass unchanged.
   task automatic resolve();
      pkt_t p;
      logic [15:0] ix;
      while (pend_q.size() > 0) begin
         p = pend_q[0];
         if (p.md[87:80] != 8'd3) begin
            void'(pend_q.pop_front());
            exp_q.push_back(p);
            m_out++;
         end else if (idx_q.size() > 0) begin
            void'(pend_q.pop_front());
            ix = idx_q.pop_front();
            if (ix[15]) begin
               m_hit++;
               p.md[87:80] = 8'd7;
               p.md[63:48] = ix;
               exp_q.push_back(p);
               m_out++;
            end else begin
               m_miss++;
               m_drop++;
            end
         end else begin
            break;
         end
      end
   endtask

   // ------------------------------------------------------------ compare process
   always @(negedge clk) begin
      pkt_t e;
      if (rst_n) begin
         chk("wr_pair", bus.out_gme_md_wr === bus.out_gme_phv_wr,
             256'(bus.out_gme_phv_wr), 256'(bus.out_gme_md_wr));
         if (bus.out_gme_md_wr === 1'b1) begin
            n_seen++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1'b0, bus.out_gme_md, 256'h0);
            end else begin
               e = exp_q.pop_front();
               chk("out_md", bus.out_gme_md === e.md, bus.out_gme_md, e.md);
               chk("out_phv", bus.out_gme_phv === e.phv, bus.out_gme_phv[255:0],
                   e.phv[255:0]);
            end
         end else begin
            chk("idle_zero", (bus.out_gme_md === '0) && (bus.out_gme_phv === '0),
                bus.out_gme_md, 256'h0);
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.in_gme_md_wr    = 1'b0;
      bus.in_gme_phv_wr   = 1'b0;
      bus.in_gme_key_wr   = 1'b0;
      bus.in_gme_index_wr = 1'b0;
      bus.in_gme_md       = '0;
   endtask

   task automatic send(input logic [255:0] md, input logic [1023:0] phv, input logic kwr,
                       input logic [511:0] key, input logic iwr, input logic [15:0] idx);
      pkt_t p;
      bus.in_gme_md       = md;
      bus.in_gme_md_wr    = 1'b1;
      bus.in_gme_phv      = phv;
      bus.in_gme_phv_wr   = 1'b1;
      bus.in_gme_key      = key;
      bus.in_gme_key_wr   = kwr;
      bus.in_gme_index    = idx;
      bus.in_gme_index_wr = iwr;
      p.md  = md;
      p.phv = phv;
      if (pend_q.size() < 256) begin
         pend_q.push_back(p);
         m_in++;
      end
      if (iwr) idx_q.push_back(idx);
      resolve();
      tick();
      clear_in();
   endtask

   task automatic send_idx(input logic [15:0] idx);
      bus.in_gme_index    = idx;
      bus.in_gme_index_wr = 1'b1;
      idx_q.push_back(idx);
      resolve();
      tick();
      clear_in();
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_cnt_in"},   cnt_in_md  == m_in,   256'(cnt_in_md),  256'(m_in));
      chk({tag, "_cnt_out"},  cnt_out_md == m_out,  256'(cnt_out_md), 256'(m_out));
      chk({tag, "_cnt_hit"},  cnt_hit    == m_hit,  256'(cnt_hit),    256'(m_hit));
      chk({tag, "_cnt_miss"}, cnt_miss   == m_miss, 256'(cnt_miss),   256'(m_miss));
      chk({tag, "_cnt_drop"}, cnt_drop   == m_drop, 256'(cnt_drop),   256'(m_drop));
      chk({tag, "_drained"},  exp_q.size() == 0,    256'(exp_q.size()), 256'h0);
   endtask

   initial begin
      int seen0;
      int n;
      logic [255:0] md;
      rst_n = 1'b0;
      bus.in_gme_key = '0;  bus.in_gme_phv = '0;  bus.in_gme_index = '0;
      clear_in();
      bus.in_gme_key_alf = 1'b0;  bus.in_gme_md_alf = 1'b0;  bus.in_gme_phv_alf = 1'b0;
      bus.cin_gme_data = 134'h2_0000_0000_0000_0000_0000_0000_00AB_CDEF;
      bus.cin_gme_data_wr = 1'b1;
      bus.cin_gme_ready   = 1'b1;
      model_reset();
      repeat (3) tick();

      // Reset state and combinational config path.
      chk("rst_md_wr",  bus.out_gme_md_wr === 1'b0, 256'(bus.out_gme_md_wr), 256'h0);
      chk("rst_key_wr", bus.out_gme_key_wr === 1'b0, 256'(bus.out_gme_key_wr), 256'h0);
      chk("rst_key",    bus.out_gme_key === '0, bus.out_gme_key[255:0], 256'h0);
      chk("rst_md",     bus.out_gme_md === '0, bus.out_gme_md, 256'h0);
      chk("rst_ovf",    err_ovf === 1'b0, 256'(err_ovf), 256'h0);
      chk("rst_cnt",    (cnt_in_md | cnt_out_md | cnt_hit | cnt_miss | cnt_drop) === 32'h0,
          256'(cnt_in_md | cnt_out_md), 256'h0);
      chk("cfg_data", bus.cout_gme_data === 134'h2_0000_0000_0000_0000_0000_0000_00AB_CDEF,
          256'(bus.cout_gme_data), 256'h2_0000_0000_0000_0000_0000_0000_00AB_CDEF);
      chk("cfg_wr_rdy", {bus.cout_gme_data_wr, bus.cout_gme_ready} === 2'b11,
          256'({bus.cout_gme_data_wr, bus.cout_gme_ready}), 256'h3);
      rst_n = 1'b1;
      tick();

      // Pass-through: module ID 5, PHV A5, out at t+2, no key.
      md = mk_md(8'd5, 32'h1111_0001);
      send(md, 1024'hA5, 1'b1, 512'h77, 1'b0, 16'h0);
      chk("pass_no_key", bus.out_gme_key_wr === 1'b0, 256'(bus.out_gme_key_wr), 256'h0);
      tick();
      chk("pass_wr_t2", bus.out_gme_md_wr === 1'b1, 256'(bus.out_gme_md_wr), 256'h1);
      chk("pass_phv", bus.out_gme_phv === 1024'hA5, bus.out_gme_phv[255:0], 256'hA5);
      chk("pass_md", bus.out_gme_md === md, bus.out_gme_md, md);
      tick();
      chk("pass_one_cycle", bus.out_gme_md_wr === 1'b0, 256'(bus.out_gme_md_wr), 256'h0);
      repeat (3) tick();
      chk("pass_cnt_out", cnt_out_md === 32'd1, 256'(cnt_out_md), 256'd1);

      // Merge hit: key out at t+1, MD waits for the index.
      md = mk_md(8'd3, 32'h2222_0002);
      send(md, {32{32'h2222_0002}}, 1'b1, 512'h1234, 1'b0, 16'h0);
      chk("key_wr_t1", bus.out_gme_key_wr === 1'b1, 256'(bus.out_gme_key_wr), 256'h1);
      chk("key_val", bus.out_gme_key === 512'h1234, bus.out_gme_key[255:0], 256'h1234);
      tick();
      chk("key_wr_pulse", bus.out_gme_key_wr === 1'b0, 256'(bus.out_gme_key_wr), 256'h0);
      seen0 = n_seen;
      repeat (5) tick();
      chk("merge_waits", n_seen == seen0, 256'(n_seen), 256'(seen0));
      send_idx(16'h8123);
      tick();
      chk("merge_wr", bus.out_gme_md_wr === 1'b1, 256'(bus.out_gme_md_wr), 256'h1);
      chk("merge_nmid", bus.out_gme_md[87:80] === 8'd7, 256'(bus.out_gme_md[87:80]), 256'h7);
      chk("merge_idx", bus.out_gme_md[63:48] === 16'h8123, 256'(bus.out_gme_md[63:48]),
          256'h8123);
      repeat (3) tick();
      chk("merge_cnt_hit", cnt_hit === 32'd1, 256'(cnt_hit), 256'd1);

      // Miss with DROP_MISS=1, followed by a pass packet that must still appear.
      send(mk_md(8'd3, 32'h3333_0003), {32{32'h3333_0003}}, 1'b0, '0, 1'b1, 16'h0042);
      send(mk_md(8'd9, 32'h4444_0004), {32{32'h4444_0004}}, 1'b0, '0, 1'b0, 16'h0);
      repeat (8) tick();
      chk("miss_cnt_drop", cnt_drop === 32'd1, 256'(cnt_drop), 256'd1);
      chk("miss_cnt_miss", cnt_miss === 32'd1, 256'(cnt_miss), 256'd1);
      chk_counters("miss");

      // Backpressure: three packets held, then released at 2-cycle spacing.
      bus.in_gme_md_alf = 1'b1;
      for (int i = 0; i < 3; i++)
         send(mk_md(8'd10 + 8'(i), 32'hB000_0000 + i), {32{32'hB000_0000 + i}},
              1'b0, '0, 1'b0, 16'h0);
      chk("bp_alf_fwd", bus.out_gme_md_alf === 1'b1, 256'(bus.out_gme_md_alf), 256'h1);
      seen0 = n_seen;
      repeat (10) tick();
      chk("bp_hold", n_seen == seen0, 256'(n_seen), 256'(seen0));
      bus.in_gme_md_alf = 1'b0;
      repeat (10) tick();
      chk("bp_release", n_seen == seen0 + 3, 256'(n_seen), 256'(seen0 + 3));
      n = wr_cyc.size();
      chk("bp_space1", wr_cyc[n-1] - wr_cyc[n-2] == 2, 256'(wr_cyc[n-1] - wr_cyc[n-2]), 256'd2);
      chk("bp_space2", wr_cyc[n-2] - wr_cyc[n-3] == 2, 256'(wr_cyc[n-2] - wr_cyc[n-3]), 256'd2);
      bus.in_gme_phv_alf = 1'b1;
      #1;
      chk("phv_alf_fwd", bus.out_gme_phv_alf === 1'b1, 256'(bus.out_gme_phv_alf), 256'h1);
      bus.in_gme_phv_alf = 1'b0;
      chk_counters("bp");

      // Fresh start, then fill the FIFOs with served packets that have no index.
      rst_n = 1'b0;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 250; i++)
         send(mk_md(8'd3, 32'hF000_0000 + i), {32{32'hF000_0000 + i}}, 1'b0, '0, 1'b0, 16'h0);
      chk("alf_250", bus.out_gme_md_alf === 1'b0, 256'(bus.out_gme_md_alf), 256'h0);
      send(mk_md(8'd3, 32'hF000_00FA), {32{32'hF000_00FA}}, 1'b0, '0, 1'b0, 16'h0);
      chk("alf_251", bus.out_gme_md_alf === 1'b1, 256'(bus.out_gme_md_alf), 256'h1);
      chk("phv_alf_251", bus.out_gme_phv_alf === 1'b1, 256'(bus.out_gme_phv_alf), 256'h1);
      for (int i = 251; i < 256; i++)
         send(mk_md(8'd3, 32'hF000_0000 + i), {32{32'hF000_0000 + i}}, 1'b0, '0, 1'b0, 16'h0);
      chk("ovf_at_256", err_ovf === 1'b0, 256'(err_ovf), 256'h0);
      for (int i = 256; i < 258; i++)
         send(mk_md(8'd3, 32'hF000_0000 + i), {32{32'hF000_0000 + i}}, 1'b0, '0, 1'b0, 16'h0);
      chk("ovf_set", err_ovf === 1'b1, 256'(err_ovf), 256'h1);
      chk("full_cnt_in", cnt_in_md === 32'd256, 256'(cnt_in_md), 256'd256);
      chk("full_cnt_model", cnt_in_md == m_in, 256'(cnt_in_md), 256'(m_in));

      // Reset while a merged packet sits in EMIT.
      send_idx(16'h8001);
      tick();
      chk("emit_before_rst", bus.out_gme_md_wr === 1'b1, 256'(bus.out_gme_md_wr), 256'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_wr", {bus.out_gme_md_wr, bus.out_gme_phv_wr} === 2'b00,
          256'({bus.out_gme_md_wr, bus.out_gme_phv_wr}), 256'h0);
      chk("rst_async_data", (bus.out_gme_md === '0) && (bus.out_gme_phv === '0),
          bus.out_gme_md, 256'h0);
      chk("rst_async_state", {err_ovf, cnt_in_md, cnt_hit} === 65'h0,
          256'({err_ovf, cnt_in_md, cnt_hit}), 256'h0);
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      seen0 = n_seen;
      repeat (10) tick();
      chk("no_stale_out", n_seen == seen0, 256'(n_seen), 256'(seen0));
      chk("fifo_empty_alf", bus.out_gme_md_alf === 1'b0, 256'(bus.out_gme_md_alf), 256'h0);
      send(mk_md(8'd5, 32'h5555_0005), {32{32'h5555_0005}}, 1'b0, '0, 1'b0, 16'h0);
      repeat (5) tick();
      chk("post_rst_out", n_seen == seen0 + 1, 256'(n_seen), 256'(seen0 + 1));
      chk_counters("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
